loan_io_led_ctrl: RTL and testbench
===================================

LOAN_IO_LED_CTRL -- requirements
Module: loan_io_led_ctrl

Interface
REQ-001 Parameter CH_NUM, default 4, is the number of HPS loan-IO LED channels (1..16).
REQ-002 Parameter CNT_W, default 24, is the blink half-period counter width.
REQ-003 Parameter PWM_W, default 8, is the PWM counter and duty width.
REQ-004 Parameter PRESC, default 25000, is clk_i cycles per blink tick (1 ms at 25 MHz); PRESC >= 1.
REQ-005 clk_i  in  1  single clock; the block SHALL use only this clock.
REQ-006 rst_i  in  1  reset, asynchronous and active-high.
REQ-007 avs_address  in  clog2(CH_NUM)+2  word address; channel = addr[MSB:2], register = addr[1:0].
REQ-008 avs_write, avs_read  in  1  Avalon-MM strobes, zero wait states.
REQ-009 avs_writedata  in  32  write data.
REQ-010 avs_readdata  out  32  read data.
REQ-011 avs_readdatavalid  out  1  read data qualifier.
REQ-012 loan_io_in  in  CH_NUM  asynchronous pad inputs from HPS loan IO.
REQ-013 loan_io_out  out  CH_NUM  drive values to HPS loan IO.
REQ-014 loan_io_oe  out  CH_NUM  output enables to HPS loan IO.

Function
REQ-015 Per-channel registers: 0 CTRL {inv[3], oe[2], mode[1:0]}; 1 HALF_PERIOD[CNT_W-1:0]; 2 DUTY[PWM_W-1:0]; 3 STATUS {rise_sticky[1], in_sync[0]}.
REQ-016 Modes: 0 OFF (0), 1 ON (1), 2 BLINK, 3 PWM; loan_io_out = mode value XOR inv.
REQ-017 loan_io_oe[ch] SHALL equal CTRL.oe; out and oe registered, 1 cycle after the CTRL write.
REQ-018 Global prescaler emits a 1-cycle tick every PRESC clk_i cycles, free-running from reset.
REQ-019 BLINK: on each tick the channel counter increments; at HALF_PERIOD-1 it clears and the phase toggles.
REQ-020 BLINK with HALF_PERIOD=0: phase held at 0, counter held at 0.
REQ-021 PWM: shared free-running PWM_W counter increments every clk_i cycle; value = (pwm_cnt < DUTY); DUTY=0 gives constant 0.
REQ-022 A write to CTRL or HALF_PERIOD clears that channel's counter and phase; on coincidence with a tick, the write wins.
REQ-023 loan_io_in passes through a 2-flop synchroniser; in_sync is the second-stage value.
REQ-024 rise_sticky sets on a 0->1 of in_sync; a write with bit1=1 to STATUS clears it; set wins over simultaneous clear.
REQ-025 Reads: avs_readdatavalid and avs_readdata assert 1 cycle after avs_read; unused bits read 0.
REQ-026 Addresses for channel >= CH_NUM: writes ignored, reads return 0 with normal valid.
REQ-027 Simultaneous avs_read and avs_write to the same register: read returns the pre-write value.

Reset
REQ-028 rst_i asserted: loan_io_out=0, loan_io_oe=0, avs_readdatavalid=0, avs_readdata=0, all registers, counters, synchronisers and the prescaler cleared.
REQ-029 Reset asserted mid-blink or mid-read drops all state immediately; no pending readdatavalid after release.

Configuration
REQ-030 With LOAN_IO_PWM_EN defined: PWM mode, DUTY registers and the PWM counter exist.
REQ-031 Without LOAN_IO_PWM_EN: mode 3 behaves as OFF, DUTY reads 0, writes to it are ignored, and the PWM counter is not instantiated.

Structure
REQ-032 Package loan_io_led_pkg SHALL hold the mode enum, the register offset constants and the CTRL bit positions.
REQ-033 Sub-module loan_io_led_ch SHALL implement one channel (CTRL/HALF_PERIOD/DUTY state, blink counter, output logic) and is generated CH_NUM times.
REQ-034 The prescaler, the PWM counter, the synchronisers and the read mux reside in loan_io_led_ctrl.

Verification
REQ-035 PRESC=4, ch0 CTRL=0x6 (oe, BLINK), HALF_PERIOD=3 -> loan_io_out[0] toggles every 12 clk_i cycles, loan_io_oe[0]=1.
REQ-036 PWM_EN, ch1 CTRL=0x7, DUTY=64 -> out high 64 of every 256 cycles; DUTY=0 -> constant 0; CTRL=0xF -> inverted.
REQ-037 Pulse loan_io_in[2] 0->1 -> STATUS ch2 reads 0x3 from 2 cycles later; write 0x2 -> reads 0x1; coincident edge and clear -> stays 0x3.
REQ-038 Write HALF_PERIOD on the tick cycle mid-blink -> phase 0, next toggle exactly HALF_PERIOD ticks later.
REQ-039 Read with channel index CH_NUM -> readdata 0, valid 1 cycle later; rst_i asserted during blink -> out/oe 0 in the same cycle.

Source files
------------

// File: rtl/loan_io_led_pkg.sv
// Shared types and register map for the HPS loan-IO LED controller.
// Build with LOAN_IO_PWM_EN defined to include the PWM mode and DUTY registers.
package loan_io_led_pkg;

   typedef enum logic [1:0] {
      ModeOff   = 2'd0,
      ModeOn    = 2'd1,
      ModeBlink = 2'd2,
      ModePwm   = 2'd3
   } mode_e;

   localparam logic [1:0] RegCtrl   = 2'd0;
   localparam logic [1:0] RegHalf   = 2'd1;
   localparam logic [1:0] RegDuty   = 2'd2;
   localparam logic [1:0] RegStatus = 2'd3;

   localparam int unsigned CtrlW         = 4;
   localparam int unsigned CtrlInvBit    = 3;
   localparam int unsigned CtrlOeBit     = 2;
   localparam int unsigned StatusRiseBit = 1;

endpackage

// File: rtl/loan_io_led_ch.sv
// One LED channel: CTRL/HALF_PERIOD/DUTY state, blink counter and registered pad drive.
// PWM mode and DUTY exist only when LOAN_IO_PWM_EN is defined.
module loan_io_led_ch
   import loan_io_led_pkg::*;
#(
   parameter int unsigned CNT_W = 24,
   parameter int unsigned PWM_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             tick_i,
   input  logic             wr_ctrl_i,
   input  logic             wr_half_i,
`ifdef LOAN_IO_PWM_EN
   input  logic             wr_duty_i,
   input  logic [PWM_W-1:0] duty_wdata_i,
   input  logic [PWM_W-1:0] pwm_cnt_i,
   output logic [PWM_W-1:0] duty_o,
`endif
   input  logic [CtrlW-1:0] ctrl_wdata_i,
   input  logic [CNT_W-1:0] half_wdata_i,
   output logic [CtrlW-1:0] ctrl_o,
   output logic [CNT_W-1:0] half_o,
   output logic             out_o,
   output logic             oe_o
);

   logic [CtrlW-1:0] ctrl_q, ctrl_d;
   logic [CNT_W-1:0] half_q, half_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;
   logic             out_q, out_d;
   logic             oe_q, oe_d;
   logic             mode_val;
   mode_e            mode_d;
`ifdef LOAN_IO_PWM_EN
   logic [PWM_W-1:0] duty_q, duty_d;
`endif

   always_comb begin
      ctrl_d  = wr_ctrl_i ? ctrl_wdata_i : ctrl_q;
      half_d  = wr_half_i ? half_wdata_i : half_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      // A configuration write restarts the blink even on a tick cycle.
      if (wr_ctrl_i || wr_half_i) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (tick_i && (mode_e'(ctrl_q[1:0]) == ModeBlink)) begin
         if (half_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
         end else if (cnt_q == half_q - CNT_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

`ifdef LOAN_IO_PWM_EN
   assign duty_d = wr_duty_i ? duty_wdata_i : duty_q;
`endif

   // Output registers follow the next state so the pad reflects a write one cycle later.
   assign mode_d = mode_e'(ctrl_d[1:0]);

   always_comb begin
      mode_val = 1'b0;
      unique case (mode_d)
         ModeOff:   mode_val = 1'b0;
         ModeOn:    mode_val = 1'b1;
         ModeBlink: mode_val = phase_d;
`ifdef LOAN_IO_PWM_EN
         ModePwm:   mode_val = (pwm_cnt_i < duty_d);
`else
         ModePwm:   mode_val = 1'b0;
`endif
         default:   mode_val = 1'b0;
      endcase
      out_d = mode_val ^ ctrl_d[CtrlInvBit];
      oe_d  = ctrl_d[CtrlOeBit];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctrl_q  <= '0;
         half_q  <= '0;
         cnt_q   <= '0;
         phase_q <= 1'b0;
         out_q   <= 1'b0;
         oe_q    <= 1'b0;
`ifdef LOAN_IO_PWM_EN
         duty_q  <= '0;
`endif
      end else begin
         ctrl_q  <= ctrl_d;
         half_q  <= half_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         out_q   <= out_d;
         oe_q    <= oe_d;
`ifdef LOAN_IO_PWM_EN
         duty_q  <= duty_d;
`endif
      end
   end

   assign ctrl_o = ctrl_q;
   assign half_o = half_q;
   assign out_o  = out_q;
   assign oe_o   = oe_q;
`ifdef LOAN_IO_PWM_EN
   assign duty_o = duty_q;
`endif

endmodule

// File: rtl/loan_io_led_ctrl.sv
// Avalon-MM LED controller for HPS loan-IO pads: prescaler, PWM counter, input sync, read mux.
// Define LOAN_IO_PWM_EN to build the PWM mode, DUTY registers and shared PWM counter.
module loan_io_led_ctrl
   import loan_io_led_pkg::*;
#(
   parameter int unsigned CH_NUM = 4,
   parameter int unsigned CNT_W  = 24,
   parameter int unsigned PWM_W  = 8,
   parameter int unsigned PRESC  = 25000,
   localparam int unsigned AW    = $clog2(CH_NUM) + 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [AW-1:0]     avs_address,
   input  logic              avs_write,
   input  logic              avs_read,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic              avs_readdatavalid,
   input  logic [CH_NUM-1:0] loan_io_in,
   output logic [CH_NUM-1:0] loan_io_out,
   output logic [CH_NUM-1:0] loan_io_oe
);

   localparam int unsigned PsW = (PRESC > 1) ? $clog2(PRESC) : 1;

   logic [PsW-1:0]    presc_q, presc_d;
   logic              tick;
   logic [31:0]       ch_idx;
   logic [1:0]        reg_sel;
   logic [CH_NUM-1:0] wr_ctrl, wr_half, rise_clr;
   logic [CH_NUM-1:0] sync1_q, sync2_q, rise_q, rise_d;
   logic [CtrlW-1:0]  ctrl_rd [CH_NUM];
   logic [CNT_W-1:0]  half_rd [CH_NUM];
   logic [31:0]       rdata_q, rdata_d;
   logic              rvalid_q;
   logic              unused_wdata;
`ifdef LOAN_IO_PWM_EN
   logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
   logic [CH_NUM-1:0] wr_duty;
   logic [PWM_W-1:0]  duty_rd [CH_NUM];

   assign pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
`endif

   assign tick         = (presc_q == PsW'(PRESC - 1));
   assign presc_d      = tick ? '0 : presc_q + PsW'(1);
   assign ch_idx       = 32'(avs_address) >> 2;
   assign reg_sel      = avs_address[1:0];
   assign unused_wdata = ^avs_writedata;
   // Set wins over a coincident clear.
   assign rise_d       = (rise_q & ~rise_clr) | (sync1_q & ~sync2_q);

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      logic sel;
      assign sel         = avs_write && (ch_idx == 32'(i));
      assign wr_ctrl[i]  = sel && (reg_sel == RegCtrl);
      assign wr_half[i]  = sel && (reg_sel == RegHalf);
      assign rise_clr[i] = sel && (reg_sel == RegStatus) && avs_writedata[StatusRiseBit];
`ifdef LOAN_IO_PWM_EN
      assign wr_duty[i]  = sel && (reg_sel == RegDuty);
`endif

      loan_io_led_ch #(
         .CNT_W(CNT_W),
         .PWM_W(PWM_W)
      ) u_ch (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .tick_i      (tick),
         .wr_ctrl_i   (wr_ctrl[i]),
         .wr_half_i   (wr_half[i]),
`ifdef LOAN_IO_PWM_EN
         .wr_duty_i   (wr_duty[i]),
         .duty_wdata_i(avs_writedata[PWM_W-1:0]),
         .pwm_cnt_i   (pwm_cnt_d),
         .duty_o      (duty_rd[i]),
`endif
         .ctrl_wdata_i(avs_writedata[CtrlW-1:0]),
         .half_wdata_i(avs_writedata[CNT_W-1:0]),
         .ctrl_o      (ctrl_rd[i]),
         .half_o      (half_rd[i]),
         .out_o       (loan_io_out[i]),
         .oe_o        (loan_io_oe[i])
      );
   end

   // Registers are sampled before the write lands, so a same-cycle read sees the old value.
   always_comb begin
      rdata_d = '0;
      if (avs_read) begin
         for (int i = 0; i < CH_NUM; i++) begin
            if (ch_idx == 32'(i)) begin
               case (reg_sel)
                  RegCtrl:   rdata_d = 32'(ctrl_rd[i]);
                  RegHalf:   rdata_d = 32'(half_rd[i]);
`ifdef LOAN_IO_PWM_EN
                  RegDuty:   rdata_d = 32'(duty_rd[i]);
`endif
                  RegStatus: rdata_d = {30'd0, rise_q[i], sync2_q[i]};
                  default:   rdata_d = '0;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         presc_q   <= '0;
         sync1_q   <= '0;
         sync2_q   <= '0;
         rise_q    <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
`ifdef LOAN_IO_PWM_EN
         pwm_cnt_q <= '0;
`endif
      end else begin
         presc_q   <= presc_d;
         sync1_q   <= loan_io_in;
         sync2_q   <= sync1_q;
         rise_q    <= rise_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= avs_read;
`ifdef LOAN_IO_PWM_EN
         pwm_cnt_q <= pwm_cnt_d;
`endif
      end
   end

   assign avs_readdata      = rdata_q;
   assign avs_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_loan_io_led_ctrl.sv
// Self-checking bench for loan_io_led_ctrl: directed scenarios plus random bus traffic
// compared every cycle against a tick/edge-count reference model.
module tb_loan_io_led_ctrl;

   localparam int unsigned CH_NUM = 3;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned PWM_W  = 8;
   localparam int unsigned PRESC  = 4;
   localparam int unsigned AW     = $clog2(CH_NUM) + 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [AW-1:0]     avs_address;
   logic              avs_write;
   logic              avs_read;
   logic [31:0]       avs_writedata;
   logic [31:0]       avs_readdata;
   logic              avs_readdatavalid;
   logic [CH_NUM-1:0] loan_io_in;
   logic [CH_NUM-1:0] loan_io_out;
   logic [CH_NUM-1:0] loan_io_oe;

   always #5 clk = ~clk;

   loan_io_led_ctrl #(
      .CH_NUM(CH_NUM),
      .CNT_W (CNT_W),
      .PWM_W (PWM_W),
      .PRESC (PRESC)
   ) u_dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .avs_address      (avs_address),
      .avs_write        (avs_write),
      .avs_read         (avs_read),
      .avs_writedata    (avs_writedata),
      .avs_readdata     (avs_readdata),
      .avs_readdatavalid(avs_readdatavalid),
      .loan_io_in       (loan_io_in),
      .loan_io_out      (loan_io_out),
      .loan_io_oe       (loan_io_oe)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Reference model: edges since reset, blink ticks since last restart, pad history.
   int unsigned       m_edge;
   logic [3:0]        m_ctrl  [CH_NUM];
   int unsigned       m_half  [CH_NUM];
   int unsigned       m_ticks [CH_NUM];
`ifdef LOAN_IO_PWM_EN
   int unsigned       m_duty  [CH_NUM];
`endif
   logic [CH_NUM-1:0] m_h1, m_h2, m_sticky;
   logic              m_rvalid;
   logic [31:0]       m_rdata;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_edge   = 0;
      m_h1     = '0;
      m_h2     = '0;
      m_sticky = '0;
      m_rvalid = 1'b0;
      m_rdata  = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         m_ctrl[i]  = '0;
         m_half[i]  = 0;
         m_ticks[i] = 0;
`ifdef LOAN_IO_PWM_EN
         m_duty[i]  = 0;
`endif
      end
   endtask

   function automatic logic [31:0] model_read(input logic [AW-1:0] a);
      int unsigned ch;
      ch = 32'(a) >> 2;
      if (ch >= CH_NUM) return 32'h0;
      case (a[1:0])
         2'd0:    return {28'd0, m_ctrl[ch]};
         2'd1:    return m_half[ch];
`ifdef LOAN_IO_PWM_EN
         2'd2:    return m_duty[ch];
`endif
         2'd3:    return {30'd0, m_sticky[ch], m_h2[ch]};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic model_out(input int unsigned ch);
      logic v;
      case (m_ctrl[ch][1:0])
         2'd0:    v = 1'b0;
         2'd1:    v = 1'b1;
         2'd2:    v = (m_half[ch] == 0) ? 1'b0 : 1'((m_ticks[ch] / m_half[ch]) % 2);
`ifdef LOAN_IO_PWM_EN
         default: v = ((m_edge % (1 << PWM_W)) < m_duty[ch]);
`else
         default: v = 1'b0;
`endif
      endcase
      return v ^ m_ctrl[ch][3];
   endfunction

   // One clock edge: advance the model with the inputs seen at the edge, then compare.
   task automatic step();
      int unsigned       en;
      int unsigned       ch;
      logic              tick;
      logic [1:0]        r;
      logic [CH_NUM-1:0] clr;
      logic [CH_NUM-1:0] eo, eoe;
      @(posedge clk);
      en       = m_edge + 1;
      tick     = ((en % PRESC) == 0);
      ch       = 32'(avs_address) >> 2;
      r        = avs_address[1:0];
      m_rvalid = avs_read;
      m_rdata  = avs_read ? model_read(avs_address) : 32'h0;
      clr      = '0;
      if (avs_write && ch < CH_NUM && r == 2'd3 && avs_writedata[1]) clr[ch] = 1'b1;
      m_sticky = (m_sticky & ~clr) | (m_h1 & ~m_h2);
      m_h2     = m_h1;
      m_h1     = loan_io_in;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         if (avs_write && ch == i && (r == 2'd0 || r == 2'd1)) m_ticks[i] = 0;
         else if (tick && m_ctrl[i][1:0] == 2'd2) m_ticks[i]++;
      end
      if (avs_write && ch < CH_NUM) begin
         case (r)
            2'd0:    m_ctrl[ch] = avs_writedata[3:0];
            2'd1:    m_half[ch] = 32'(avs_writedata[CNT_W-1:0]);
`ifdef LOAN_IO_PWM_EN
            2'd2:    m_duty[ch] = 32'(avs_writedata[PWM_W-1:0]);
`endif
            default: ;
         endcase
      end
      m_edge = en;
      #1;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         eo[i]  = model_out(i);
         eoe[i] = m_ctrl[i][2];
      end
      check_eq("loan_io_out", 32'(loan_io_out), 32'(eo));
      check_eq("loan_io_oe", 32'(loan_io_oe), 32'(eoe));
      check_eq("readdatavalid", 32'(avs_readdatavalid), 32'(m_rvalid));
      if (m_rvalid) check_eq("readdata", avs_readdata, m_rdata);
   endtask

   task automatic wr_reg(input int unsigned ch, input int unsigned r, input logic [31:0] d);
      avs_write     = 1'b1;
      avs_address   = AW'(ch * 4 + r);
      avs_writedata = d;
      step();
      avs_write     = 1'b0;
   endtask

   task automatic rd_reg(input int unsigned ch, input int unsigned r);
      avs_read    = 1'b1;
      avs_address = AW'(ch * 4 + r);
      step();
      avs_read    = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          last, ntog, n, hi;
      logic        prev;

      rst           = 1'b1;
      avs_address   = '0;
      avs_write     = 1'b0;
      avs_read      = 1'b0;
      avs_writedata = '0;
      loan_io_in    = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out", 32'(loan_io_out), 0);
      check_eq("rst_oe", 32'(loan_io_oe), 0);
      check_eq("rst_valid", 32'(avs_readdatavalid), 0);
      check_eq("rst_rdata", avs_readdata, 0);
      #3 rst = 1'b0;

      // Blink: PRESC=4, HALF_PERIOD=3 gives a toggle every 12 cycles.
      wr_reg(0, 0, 32'h6);
      wr_reg(0, 1, 32'h3);
      check_eq("blink_oe", 32'(loan_io_oe[0]), 1);
      prev = loan_io_out[0];
      last = -1;
      ntog = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (loan_io_out[0] !== prev) begin
            if (last >= 0) check_eq("blink_period", 32'(i - last), 12);
            last = i;
            prev = loan_io_out[0];
            ntog++;
         end
      end
      check_eq("blink_toggles", 32'(ntog >= 4), 1);

      // HALF_PERIOD rewrite landing on a tick edge while the LED is lit.
      n = 0;
      while (loan_io_out[0] !== 1'b1 && n < 30) begin
         step();
         n++;
      end
      repeat (4) step();
      for (int i = 0; i < 8 && ((m_edge + 1) % PRESC) != 0; i++) step();
      wr_reg(0, 1, 32'h2);
      check_eq("hp_wr_phase", 32'(loan_io_out[0]), 0);
      n = 0;
      while (loan_io_out[0] === 1'b0 && n < 40) begin
         step();
         n++;
      end
      check_eq("hp_next_toggle", 32'(n), 8);

      // Same-cycle read and write of CTRL returns the old value.
      avs_read      = 1'b1;
      avs_write     = 1'b1;
      avs_address   = AW'(0);
      avs_writedata = 32'hFFFF_FFF6;
      step();
      avs_read      = 1'b0;
      avs_write     = 1'b0;
      check_eq("rd_wr_old", avs_readdata, 32'h6);
      rd_reg(0, 0);
      check_eq("rd_wr_new", avs_readdata, 32'h6);

      // Rising edge capture on channel 2.
      loan_io_in[2] = 1'b1;
      step();
      step();
      rd_reg(2, 3);
      check_eq("status_rise", avs_readdata, 32'h3);
      wr_reg(2, 3, 32'h2);
      rd_reg(2, 3);
      check_eq("status_clr", avs_readdata, 32'h1);
      loan_io_in[2] = 1'b0;
      repeat (3) step();
      loan_io_in[2] = 1'b1;
      step();
      wr_reg(2, 3, 32'h2);
      rd_reg(2, 3);
      check_eq("status_set_wins", avs_readdata, 32'h3);

      // Out-of-range channel index.
      wr_reg(3, 0, 32'h5);
      rd_reg(3, 0);
      check_eq("oor_valid", 32'(avs_readdatavalid), 1);
      check_eq("oor_rdata", avs_readdata, 32'h0);

`ifdef LOAN_IO_PWM_EN
      wr_reg(1, 2, 32'd64);
      wr_reg(1, 0, 32'h7);
      hi = 0;
      for (int i = 0; i < 256; i++) begin step(); hi += int'(loan_io_out[1]); end
      check_eq("pwm_duty64", 32'(hi), 64);
      wr_reg(1, 2, 32'd0);
      hi = 0;
      for (int i = 0; i < 256; i++) begin step(); hi += int'(loan_io_out[1]); end
      check_eq("pwm_duty0", 32'(hi), 0);
      wr_reg(1, 2, 32'd64);
      wr_reg(1, 0, 32'hF);
      hi = 0;
      for (int i = 0; i < 256; i++) begin step(); hi += int'(loan_io_out[1]); end
      check_eq("pwm_inv", 32'(hi), 192);
`else
      wr_reg(1, 2, 32'd64);
      wr_reg(1, 0, 32'h7);
      hi = 0;
      for (int i = 0; i < 64; i++) begin step(); hi += int'(loan_io_out[1]); end
      check_eq("mode3_off", 32'(hi), 0);
      rd_reg(1, 2);
      check_eq("duty_reads0", avs_readdata, 32'h0);
      wr_reg(1, 0, 32'hF);
      hi = 0;
      for (int i = 0; i < 64; i++) begin step(); hi += int'(loan_io_out[1]); end
      check_eq("mode3_inv", 32'(hi), 64);
`endif

      // Reset mid-blink with a read outstanding.
      wr_reg(0, 0, 32'h6);
      wr_reg(0, 1, 32'h1);
      repeat (6) step();
      avs_read    = 1'b1;
      avs_address = AW'(1);
      step();
      avs_read    = 1'b0;
      rst         = 1'b1;
      #1;
      check_eq("rst_mid_out", 32'(loan_io_out), 0);
      check_eq("rst_mid_oe", 32'(loan_io_oe), 0);
      check_eq("rst_mid_valid", 32'(avs_readdatavalid), 0);
      #2 rst = 1'b0;
      model_reset();
      loan_io_in = '0;
      step();
      step();

      // Random traffic against the model.
      for (int k = 0; k < 2500; k++) begin
         avs_read      = ($urandom_range(0, 3) == 0);
         avs_write     = ($urandom_range(0, 9) == 0);
         avs_address   = AW'($urandom_range(0, (1 << AW) - 1));
         avs_writedata = $urandom();
         if (avs_address[1:0] == 2'd1) avs_writedata[CNT_W-1:0] = CNT_W'($urandom_range(0, 4));
         if ($urandom_range(0, 15) == 0) loan_io_in = CH_NUM'($urandom());
         step();
      end
      avs_read  = 1'b0;
      avs_write = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
